// File: rtl/sprite_pkg.sv
// Shared constants, types and the sprite raster address helper for the sprite blitter.
package sprite_pkg;

    localparam int unsigned SPR_W     = 36;
    localparam int unsigned SPR_H     = 36;
    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned FB_W      = 640;
    localparam int unsigned FB_H      = 480;
    localparam int unsigned FB_ADDR_W = 19;
    localparam int unsigned TRANSP    = 0;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned PIX_W     = 11;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } blit_state_t;

    typedef logic [IDX_W-1:0] pal_idx_t;

    // Linear raster index of a sprite pixel: row*SPR_W + col.
    function automatic logic [ADDR_W-1:0] raster_addr(input logic [CNT_W-1:0] row,
                                                      input logic [CNT_W-1:0] col);
        return ADDR_W'(32'(row) * SPR_W + 32'(col));
    endfunction

endpackage

// File: rtl/blit_pixel_stage.sv
// Stage 1 of the blitter: holds the pixel whose RAM data is arriving, applies the
// transparency and clip tests, and presents it to the frame-buffer port until accepted.
module blit_pixel_stage
    import sprite_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    input  logic [PIX_W-1:0]     px_i,
    input  logic [PIX_W-1:0]     py_i,
    input  pal_idx_t             data_i,
    input  logic                 fb_ready_i,
    output logic                 fb_we_o,
    output logic [FB_ADDR_W-1:0] fb_addr_o,
    output pal_idx_t             fb_data_o,
    output logic                 stall_o
);

    localparam int unsigned LIN_W = FB_ADDR_W + 2;

    logic                 valid_q, valid_d;
    logic                 visible_q, visible_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    pal_idx_t             data_q, data_d;
    logic                 hold_q, hold_d;
    pal_idx_t             pix;

    // RAM data is live on the first cycle only; a stalled pixel uses its captured copy.
    assign pix       = hold_q ? data_q : data_i;
    assign fb_we_o   = valid_q && visible_q && (pix != IDX_W'(TRANSP));
    assign stall_o   = fb_we_o && !fb_ready_i;
    assign fb_addr_o = addr_q;
    assign fb_data_o = fb_we_o ? pix : '0;

    always_comb begin
        valid_d   = valid_q;
        visible_d = visible_q;
        addr_d    = addr_q;
        data_d    = data_q;
        hold_d    = hold_q;
        if (stall_o) begin
            hold_d = 1'b1;
            if (!hold_q) begin
                data_d = data_i;
            end
        end else begin
            hold_d    = 1'b0;
            valid_d   = issue_valid_i;
            visible_d = (px_i < PIX_W'(FB_W)) && (py_i < PIX_W'(FB_H));
            if (issue_valid_i) begin
                addr_d = FB_ADDR_W'(LIN_W'(py_i) * LIN_W'(FB_W) + LIN_W'(px_i));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            visible_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            hold_q    <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            visible_q <= visible_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Copies a 36x36 palette-index sprite into the frame buffer at (dst_x, dst_y),
// skipping transparent and off-screen pixels, with frame-buffer backpressure.
module sprite_blitter
    import sprite_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [COORD_W-1:0]   dst_x,
    input  logic [COORD_W-1:0]   dst_y,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    read_address,
    input  logic [IDX_W-1:0]     data_In,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [IDX_W-1:0]     fb_data,
    input  logic                 fb_ready
);

    blit_state_t        state_q, state_d;
    logic [CNT_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   row_q, row_d;
    logic [COORD_W-1:0] dst_x_q, dst_x_d;
    logic [COORD_W-1:0] dst_y_q, dst_y_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               stall;
    logic               last_issue;
    logic               issue_valid;
    logic [PIX_W-1:0]   px;
    logic [PIX_W-1:0]   py;

    assign last_issue   = (col_q == CNT_W'(SPR_W - 1)) && (row_q == CNT_W'(SPR_H - 1));
    assign px           = PIX_W'(dst_x_q) + PIX_W'(col_q);
    assign py           = PIX_W'(dst_y_q) + PIX_W'(row_q);
    assign read_address = addr_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (!stall && last_issue) state_d = DRAIN;
            DRAIN:   if (!stall) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == RUN) || (state_q == DRAIN);
        done        = (state_q == FIN);
        issue_valid = (state_q == RUN);
    end

    // Stage 0 scan counters: advance one raster position per non-stalled RUN cycle.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        dst_x_d = dst_x_q;
        dst_y_d = dst_y_q;
        if (state_q == IDLE && start) begin
            dst_x_d = dst_x;
            dst_y_d = dst_y;
            col_d   = '0;
            row_d   = '0;
        end else if (state_q == RUN && !stall && !last_issue) begin
            if (col_q == CNT_W'(SPR_W - 1)) begin
                col_d = '0;
                row_d = row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
        addr_d = raster_addr(row_d, col_d);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            col_q   <= '0;
            row_q   <= '0;
            dst_x_q <= '0;
            dst_y_q <= '0;
            addr_q  <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            dst_x_q <= dst_x_d;
            dst_y_q <= dst_y_d;
            addr_q  <= addr_d;
        end
    end

    blit_pixel_stage u_pixel_stage (
        .clk_i         (Clk),
        .rst_i         (Reset),
        .issue_valid_i (issue_valid),
        .px_i          (px),
        .py_i          (py),
        .data_i        (data_In),
        .fb_ready_i    (fb_ready),
        .fb_we_o       (fb_we),
        .fb_addr_o     (fb_addr),
        .fb_data_o     (fb_data),
        .stall_o       (stall)
    );

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed and randomized bench for sprite_blitter with a behavioural sprite-RAM and
// a raster-order reference list of the frame-buffer writes each draw must produce.
module tb_sprite_blitter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  dst_x;
    logic [9:0]  dst_y;
    logic        busy;
    logic        done;
    logic [10:0] read_address;
    logic [2:0]  data_In;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_ready;

    logic [2:0]  mem [0:2047];

    int total;
    int bad;
    int exp_a[$];
    int exp_d[$];
    int got_a[$];
    int got_d[$];
    int first_we_n;
    int last_done_n;
    int last_stalls;

    sprite_blitter dut (
        .Clk          (clk),
        .Reset        (rst),
        .start        (start),
        .dst_x        (dst_x),
        .dst_y        (dst_y),
        .busy         (busy),
        .done         (done),
        .read_address (read_address),
        .data_In      (data_In),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_ready     (fb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite RAM with a registered read.
    always @(posedge clk) data_In <= mem[read_address];

    task automatic check(input string tag, input string what, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp);
        end
    endtask

    function automatic void build_expected(input int x, input int y);
        int px;
        int py;
        int idx;
        exp_a.delete();
        exp_d.delete();
        for (int r = 0; r < 36; r++) begin
            for (int c = 0; c < 36; c++) begin
                px  = x + c;
                py  = y + r;
                idx = int'(mem[r * 36 + c]);
                if (idx != 0 && px < 640 && py < 480) begin
                    exp_a.push_back(py * 640 + px);
                    exp_d.push_back(idx);
                end
            end
        end
    endfunction

    task automatic fill_const(input int v);
        for (int i = 0; i < 1296; i++) mem[i] = 3'(v);
    endtask

    task automatic fill_checker();
        for (int i = 0; i < 1296; i++) mem[i] = (((i / 36) + (i % 36)) % 2 == 0) ? 3'd0 : 3'd3;
    endtask

    task automatic fill_random(input int lo);
        for (int i = 0; i < 1296; i++) mem[i] = 3'($urandom_range(7, lo));
    endtask

    // mode: 0 always ready, 1 seven-cycle stall on the 3rd write, 2 random backpressure
    task automatic draw(input string tag, input int x, input int y, input int mode,
                        input int restart_at, input int reset_at);
        int n;
        int stalls;
        int stall_run;
        int done_n;
        int snap_a;
        int snap_d;
        int quiet_bad;
        int mism;
        bit in_stall;
        bit want;
        bit aborted;
        got_a.delete();
        got_d.delete();
        first_we_n = 0;
        snap_a = 0;
        snap_d = 0;
        build_expected(x, y);
        @(negedge clk);
        start    = 1'b1;
        dst_x    = 10'(x);
        dst_y    = 10'(y);
        fb_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check(tag, "ra_first", int'(read_address), 0);
        check(tag, "busy_first", int'(busy), 1);
        n = 1; stalls = 0; stall_run = 0; done_n = 0; in_stall = 1'b0; aborted = 1'b0;
        while (done_n == 0 && !aborted && n < 4000) begin
            start = 1'b0;
            if (done) begin
                done_n = n;
            end else if (n == reset_at) begin
                rst     = 1'b1;
                aborted = 1'b1;
            end else begin
                if (n == restart_at) begin
                    start = 1'b1;
                    dst_x = 10'(x + 123);
                    dst_y = 10'(y + 45);
                end
                if (fb_we) begin
                    if (first_we_n == 0) first_we_n = n;
                    case (mode)
                        1:       want = (got_a.size() == 2) && (stall_run < 7);
                        2:       want = ($urandom_range(2, 0) == 0);
                        default: want = 1'b0;
                    endcase
                    if (in_stall) begin
                        check(tag, "stall_addr", int'(fb_addr), snap_a);
                        check(tag, "stall_data", int'(fb_data), snap_d);
                    end
                    if (want) begin
                        if (!in_stall) begin
                            snap_a = int'(fb_addr);
                            snap_d = int'(fb_data);
                        end
                        in_stall = 1'b1;
                        fb_ready = 1'b0;
                        stalls++;
                        stall_run++;
                    end else begin
                        in_stall = 1'b0;
                        fb_ready = 1'b1;
                        got_a.push_back(int'(fb_addr));
                        got_d.push_back(int'(fb_data));
                    end
                end else begin
                    if (in_stall) check(tag, "stall_we_held", int'(fb_we), 1);
                    in_stall = 1'b0;
                    fb_ready = 1'b1;
                end
                n++;
                @(negedge clk);
            end
        end
        last_done_n = done_n;
        last_stalls = stalls;
        if (aborted) begin
            @(negedge clk);
            check(tag, "rst_we", int'(fb_we), 0);
            check(tag, "rst_busy", int'(busy), 0);
            check(tag, "rst_done", int'(done), 0);
            rst       = 1'b0;
            fb_ready  = 1'b1;
            quiet_bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (fb_we || done || busy) quiet_bad++;
            end
            check(tag, "rst_quiet", quiet_bad, 0);
        end else begin
            check(tag, "done_seen", int'(done_n != 0), 1);
            check(tag, "done_cycle", done_n, 1298 + stalls);
            check(tag, "busy_at_done", int'(busy), 0);
            check(tag, "n_writes", got_a.size(), exp_a.size());
            mism = 0;
            for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
                if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i]) mism++;
            end
            check(tag, "write_list", mism, 0);
            @(negedge clk);
            check(tag, "done_pulse", int'(done), 0);
            check(tag, "idle_busy", int'(busy), 0);
        end
    endtask

    initial begin
        int cnt;
        int maxa;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dst_x    = '0;
        dst_y    = '0;
        fb_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset", "busy", int'(busy), 0);
        check("reset", "done", int'(done), 0);
        check("reset", "fb_we", int'(fb_we), 0);
        check("reset", "read_address", int'(read_address), 0);
        check("reset", "fb_addr", int'(fb_addr), 0);
        check("reset", "fb_data", int'(fb_data), 0);
        rst = 1'b0;

        fill_const(5);
        draw("opaque", 0, 0, 0, 0, 0);
        check("opaque", "count", got_a.size(), 1296);
        check("opaque", "first_we_cycle", first_we_n, 2);
        check("opaque", "first_addr", (got_a.size() > 0) ? got_a[0] : -1, 0);
        check("opaque", "last_addr", (got_a.size() > 0) ? got_a[got_a.size() - 1] : -1, 22435);

        fill_checker();
        draw("transp", 100, 50, 0, 0, 0);
        check("transp", "count", got_a.size(), 648);
        cnt = 0;
        foreach (got_d[i]) if (got_d[i] != 3 || got_a[i] == 50 * 640 + 100) cnt++;
        check("transp", "bad_data_or_addr", cnt, 0);

        fill_const(6);
        draw("clip", 620, 470, 0, 0, 0);
        check("clip", "count", got_a.size(), 200);
        maxa = -1;
        foreach (got_a[i]) if (got_a[i] > maxa) maxa = got_a[i];
        check("clip", "max_addr", maxa, 479 * 640 + 639);

        fill_random(1);
        draw("backpressure", 0, 0, 1, 0, 0);
        check("backpressure", "stalls", last_stalls, 7);
        check("backpressure", "done_delay", last_done_n, 1298 + 7);

        fill_random(0);
        draw("start_busy", 200, 100, 0, 10, 0);

        draw("reset_mid", 40, 40, 0, 0, 100);
        draw("after_reset", 40, 40, 0, 0, 0);

        draw("offscreen", 700, 500, 0, 0, 0);
        check("offscreen", "count", got_a.size(), 0);

        for (int k = 0; k < 3; k++) begin
            fill_random(0);
            draw($sformatf("random%0d", k), int'($urandom_range(700, 0)),
                 int'($urandom_range(520, 0)), 2, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
